// File: rtl/bp_me_stream_mem_responder_pkg.sv
// bp_me_pkg: shared types, widths and beat-count helper for the BedRock stream memory responder
package bp_me_pkg;
  localparam int paddr_width_p = 40;
  localparam int fill_width_p = 64;
  localparam int payload_width_p = 8;
  localparam int cnt_width_p = $clog2(64*8/fill_width_p)+1;
  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;
  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0] size;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_mem_type_e msg_type;
  } bp_bedrock_mem_header_s;
  typedef enum logic [1:0] {e_ready, e_write, e_write_resp, e_read} bp_me_stream_resp_state_e;
  function automatic logic [cnt_width_p-1:0] bp_me_stream_beats(input logic [2:0] size, input int fill_width);
    int b = (8 << size) / fill_width;
    return cnt_width_p'((b < 1) ? 1 : b);
  endfunction
endpackage

// File: rtl/bp_me_stream_mem_responder_if.sv
// bp_me_stream_mem_responder_if: mem_fwd/mem_rev handshake bundle between initiator and responder
interface bp_me_stream_mem_responder_if;
  import bp_me_pkg::*;
  bp_bedrock_mem_header_s mem_fwd_header_i;
  logic [fill_width_p-1:0] mem_fwd_data_i;
  logic mem_fwd_v_i;
  logic mem_fwd_ready_and_o;
  bp_bedrock_mem_header_s mem_rev_header_o;
  logic [fill_width_p-1:0] mem_rev_data_o;
  logic mem_rev_v_o;
  logic mem_rev_ready_and_i;
  modport master (output mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_rev_ready_and_i,
                  input mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o);
  modport slave (input mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_rev_ready_and_i,
                 output mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o);
endinterface

// File: rtl/bp_me_stream_mem_responder_ram.sv
// bp_me_stream_mem_responder_ram: byte-masked sync RAM plus the 1-entry read output register
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p = 1024,
  parameter int data_width_p = 64,
  localparam int aw_lp = $clog2(els_p)
) (
  input  logic clk_i,
  input  logic v_i,
  input  logic w_i,
  input  logic [aw_lp-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [data_width_p/8-1:0] write_mask_i,
  output logic [data_width_p-1:0] data_o
);
  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] data_q;
  always_ff @(posedge clk_i) begin
    if (v_i & w_i)
      for (int i = 0; i < data_width_p/8; i++)
        if (write_mask_i[i]) mem_q[addr_i][8*i+:8] <= data_i[8*i+:8];
  end
  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) data_q <= mem_q[addr_i];
  end
  assign data_o = data_q;
endmodule

module bp_me_stream_mem_responder_ram
  import bp_me_pkg::*;
#(
  parameter int els_p = 1024,
  localparam int aw_lp = $clog2(els_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic v_i,
  input  logic w_i,
  input  logic [aw_lp-1:0] addr_i,
  input  logic [fill_width_p-1:0] data_i,
  input  logic [fill_width_p/8-1:0] mask_i,
  input  logic deq_i,
  output logic [fill_width_p-1:0] data_o,
  output logic v_o
);
  logic out_v_q, out_v_d;
  bsg_mem_1rw_sync_mask_write_byte #(.els_p(els_p), .data_width_p(fill_width_p)) mem (
    .clk_i(clk_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .write_mask_i(mask_i), .data_o(data_o)
  );
  // RAM data_o holds between reads, so it doubles as the output register payload
  always_comb out_v_d = (v_i & ~w_i) | (out_v_q & ~deq_i);
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) out_v_q <= 1'b0;
    else out_v_q <= out_v_d;
  end
  assign v_o = out_v_q;
endmodule

// File: rtl/bp_me_stream_mem_responder.sv
// bp_me_stream_mem_responder: BedRock mem_fwd/mem_rev target backed by a byte-masked sync RAM
module bp_me_stream_mem_responder
  import bp_me_pkg::*;
#(
  parameter int els_p = 1024
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_stream_mem_responder_if.slave io
);
  localparam int bw_lp = fill_width_p/8;
  localparam int lbw_lp = $clog2(bw_lp);
  localparam int aw_lp = $clog2(els_p);
  bp_me_stream_resp_state_e state_q, state_d;
  bp_bedrock_mem_header_s hdr_q, hdr_d;
  bp_bedrock_mem_type_e msg_type;
  logic [cnt_width_p-1:0] cnt_q, cnt_d, n;
  logic [2:0] size;
  logic [aw_lp+lbw_lp-1:0] addr;
  logic [bw_lp-1:0] mask;
  logic [fill_width_p-1:0] ram_data;
  logic ready_q, ready_d, ram_v, ram_w, out_v, deq, is_wr, is_rd, fwd_hs;
  always_comb begin
    msg_type = (state_q == e_ready) ? io.mem_fwd_header_i.msg_type : hdr_q.msg_type;
    size = (state_q == e_ready) ? io.mem_fwd_header_i.size : hdr_q.size;
    addr = (state_q == e_ready) ? io.mem_fwd_header_i.addr[aw_lp+lbw_lp-1:0] : hdr_q.addr[aw_lp+lbw_lp-1:0];
    n = bp_me_stream_beats(size, fill_width_p);
    is_wr = msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
    is_rd = msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
    mask = (int'(size) >= lbw_lp) ? '1 : bw_lp'(((1 << (1 << size)) - 1) << addr[lbw_lp-1:0]);
    fwd_hs = io.mem_fwd_v_i & ready_q;
    deq = (state_q == e_read) & out_v & io.mem_rev_ready_and_i;
    state_d = state_q;
    hdr_d = hdr_q;
    cnt_d = cnt_q;
    ram_v = 1'b0;
    ram_w = 1'b0;
    case (state_q)
      e_ready: if (fwd_hs) begin
        hdr_d = io.mem_fwd_header_i;
        cnt_d = cnt_width_p'(1);
        ram_v = is_wr | is_rd;
        ram_w = is_wr;
        state_d = is_rd ? e_read : (is_wr && n > cnt_width_p'(1)) ? e_write : e_write_resp;
      end
      e_write: if (fwd_hs) begin
        ram_v = 1'b1;
        ram_w = 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == n - 1'b1) ? e_write_resp : e_write;
      end
      e_write_resp: if (io.mem_rev_ready_and_i) begin
        state_d = e_ready;
        cnt_d = '0;
      end
      e_read: begin
        // one read in flight at most, so the output register always holds beat cnt_q-1
        ram_v = (cnt_q < n) & (~out_v | io.mem_rev_ready_and_i);
        cnt_d = cnt_q + cnt_width_p'(ram_v);
        if (deq && cnt_q == n) begin
          state_d = e_ready;
          cnt_d = '0;
        end
      end
    endcase
    ready_d = state_d inside {e_ready, e_write};
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      hdr_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q <= hdr_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
    end
  end
  bp_me_stream_mem_responder_ram #(.els_p(els_p)) ram (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(ram_v & reset_n_i), .w_i(ram_w),
    .addr_i(addr[lbw_lp+:aw_lp] + aw_lp'(cnt_q)),
    .data_i(io.mem_fwd_data_i), .mask_i(mask),
    .deq_i(deq), .data_o(ram_data), .v_o(out_v)
  );
  assign io.mem_fwd_ready_and_o = ready_q;
  assign io.mem_rev_header_o = hdr_q;
  assign io.mem_rev_v_o = (state_q == e_write_resp) | ((state_q == e_read) & out_v);
  assign io.mem_rev_data_o = (state_q == e_read) ? ram_data : '0;
endmodule

// File: doc/bp_me_stream_mem_responder.md
# bp_me_stream_mem_responder

BedRock memory-stream responder: the target end of the `mem_fwd`/`mem_rev` interface that UCE/LCE-side initiators drive. It accepts forward headers and data beats, and performs reads and writes against an on-block synchronous byte-masked RAM. It returns one reverse message per forward message. It is used as the backing memory behind a core's I$, D$ and I/O ports in unit-level and lite-system testbenches.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: supplies `paddr_width_p`, `bedrock_fill_width_p` (F, bits) and the header widths.
- `els_p`, 1024: RAM depth in F-bit words. Capacity is `els_p*F/8` bytes.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: reset, synchronous, active-low.
- `mem_fwd_header_i`, in, `mem_fwd_header_width_lp`: `bp_bedrock_mem_fwd_header_s`. Held stable across all beats of a message.
- `mem_fwd_data_i`, in, F: forward data beat.
- `mem_fwd_v_i`, in, 1: forward beat valid.
- `mem_fwd_ready_and_o`, out, 1: beat accepted when `v_i & ready_and_o`.
- `mem_rev_header_o`, out, `mem_rev_header_width_lp`: reverse header.
- `mem_rev_data_o`, out, F: reverse data beat.
- `mem_rev_v_o`, out, 1: reverse beat valid.
- `mem_rev_ready_and_i`, in, 1: reverse beat consumed when `v_o & ready_and_i`.

## Operation
- Beats per message: `N = max(1, (8<<size)/F)`, where `size` encodes 2^size bytes (0..6).
- Word index: `(addr / (F/8)) mod els_p`. Addresses wrap silently; there is no error response.
- Reverse header: a copy of the forward header; `msg_type`, `addr`, `size` and `payload` are unchanged.
- States:
  - `e_ready`: `ready_and_o=1`.
    - Accepting `e_bedrock_mem_wr` or `e_bedrock_mem_uc_wr` latches the header, writes beat 0 to the RAM, and goes to `e_write` if N>1, else `e_write_resp`.
    - Accepting `e_bedrock_mem_rd` or `e_bedrock_mem_uc_rd` latches the header and goes to `e_read`. This accept consumes the single data beat that accompanies the read header, and the data is ignored.
    - Any other `msg_type` goes to `e_write_resp` with no RAM side effect.
  - `e_write`: `ready_and_o=1`. Writes one beat per accepted cycle to word `base+beat`. After beat N-1 it goes to `e_write_resp`.
  - `e_write_resp`: `rev_v_o=1` and `rev_data_o=0`. On handshake it goes to `e_ready`.
  - `e_read`:
    - Issues RAM reads for words `base..base+N-1` in order.
    - The 1-entry output register presents each beat with `rev_v_o=1`.
    - A new RAM read is issued only if the output register is empty or is being dequeued in the same cycle.
    - After the handshake of beat N-1 it goes to `e_ready`.
- Write byte mask:
  - If `size >= log2(F/8)`, all bytes are written.
  - Otherwise the mask covers bytes `[addr mod F/8, +2^size)`, with data taken from the same byte lanes of `data_i`.
- Sub-F reads return the full aligned F-bit word.
- Beat counter width: `$clog2(64*8/F)+1`. The counter clears on every transition into `e_ready`.

## Timing
- Reset (`reset_n_i=0` at a posedge), next cycle:
  - state = `e_ready`, `mem_fwd_ready_and_o=0`, `mem_rev_v_o=0`, header and data outputs = 0, beat counter = 0, output register empty.
  - `ready_and_o` goes to 1 in the first cycle after reset is released.
- Reset mid-message: in-flight beats are dropped, no response is produced, and RAM contents written so far persist.
- Write: one beat accepted per cycle. `rev_v_o` rises the cycle after the last beat is accepted.
- Read:
  - `rev_v_o` rises 1 cycle after header accept (RAM read latency 1).
  - With `ready_and_i` held at 1, beats stream at one per cycle, so an N-beat read completes in N+1 cycles.
- Stall: `rev_header_o` and `rev_data_o` stay stable while `v_o & ~ready_and_i`.
- `mem_fwd_ready_and_o=0` in `e_read` and `e_write_resp`. There is no overlap of messages.

## Structure
- `bp_me_pkg` holds:
  - the state enum `bp_me_stream_resp_state_e`;
  - a function `bp_me_stream_beats(size, fill_width)`.
- One sub-module, `bp_me_stream_mem_responder_ram`, wraps `bsg_mem_1rw_sync_mask_write_byte` (`els_p` x F) and owns the output register and its valid bit.

## Test plan
All scenarios use F=64 and `els_p=1024`.
- 8B write to 0x80, data 0xDEADBEEF_CAFEF00D, followed by an 8B read of 0x80 → write ack with data 0; read returns 0xDEADBEEF_CAFEF00D and a header with addr 0x80, msg `rd`.
- 64B write to 0x0, beats 0..7 with data = beat index, followed by a 64B read with `ready_and_i=1` → `rev_v_o` the cycle after accept, then 8 consecutive beats 0..7, back in `e_ready` 9 cycles after accept.
- 8B write of 0 to 0x100, then a 1B write of 0xAB to 0x103, then an 8B read of 0x100 → 0x00000000_AB000000.
- 64B read with `ready_and_i` toggling 1/0 every cycle → 8 beats in order with no duplicates or drops, and data stable during stalls.
- `reset_n_i=0` during beat 4 of an 8-beat write → next cycle all outputs are 0. After release, a fresh 8B read of the beat-2 word returns 2 (beats 0..3 were written).
- 8B write of 0x55 to 0x2000 (wraps to word 0), then a read of 0x0 → 0x55.
